// File: rtl/jk_counter_ctrl_pkg.sv
// Shared encodings for the JK counter sequencer: command opcodes and FSM states.
package jk_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_STOP  = 2'b00,
    OP_CLEAR = 2'b01,
    OP_LOAD  = 2'b10,
    OP_RUN   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_APPLY = 2'b10
  } state_e;

endpackage

// File: rtl/jk_counter_ctrl_if.sv
// Command channel of the JK counter sequencer: valid/ready handshake plus opcode and load data.
interface jk_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  import jk_ctrl_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/jk_counter_ctrl_cell.sv
// Single JK flip-flop storage cell with synchronous active-high reset to 0.
module jk_cell (
  input  logic clock,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_counter_ctrl.sv
// Modulo-N counter sequencer driving a bank of JK cells; all count changes go through J/K.
// Optional down-count with underflow wrap is built when JK_CTRL_DOWN_EN is defined.
module jk_counter_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clock,
  input  logic             reset,
`ifdef JK_CTRL_DOWN_EN
  input  logic             dir,
`endif
  jk_counter_ctrl_if.slave cmd,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  state_e           state_q, state_d;
  logic             resume_q, resume_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] up_tgl;
  logic [WIDTH-1:0] dn_tgl;
  logic             accept;
  logic             down_mode;

  assign cmd.cmd_ready = !reset && (state_q != ST_APPLY);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign busy          = (state_q != ST_IDLE);

`ifdef JK_CTRL_DOWN_EN
  assign down_mode = dir;
`else
  assign down_mode = 1'b0;
`endif

  // Bit i toggles when every lower bit is 1 (up) or 0 (down).
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tgl
    if (gi == 0) begin : g_lsb
      assign up_tgl[gi] = 1'b1;
      assign dn_tgl[gi] = 1'b1;
    end else begin : g_upper
      assign up_tgl[gi] = &count[gi-1:0];
      assign dn_tgl[gi] = ~|count[gi-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_RUN:  state_d = ST_RUN;
            OP_STOP: state_d = ST_IDLE;
            OP_CLEAR: begin
              state_d  = ST_APPLY;
              resume_d = (state_q == ST_RUN);
              target_d = '0;
            end
            OP_LOAD: begin
              state_d  = ST_APPLY;
              resume_d = (state_q == ST_RUN);
              target_d = ({1'b0, cmd.cmd_data} >= MOD_EXT) ? MAX_CNT : cmd.cmd_data;
            end
            default: state_d = state_q;
          endcase
        end
      end
      ST_APPLY: state_d = resume_q ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    j_vec = '0;
    k_vec = '0;
    tc    = 1'b0;
    case (state_q)
      ST_APPLY: begin
        j_vec = target_q;
        k_vec = ~target_q;
      end
      ST_RUN: begin
        if (down_mode) begin
          // Underflow forces the bank to MODULUS-1 bit by bit.
          if (count == '0) begin
            tc    = 1'b1;
            j_vec = MAX_CNT & ~count;
            k_vec = ~MAX_CNT & count;
          end else begin
            j_vec = dn_tgl;
            k_vec = dn_tgl;
          end
        end else begin
          if (count == MAX_CNT) begin
            tc    = 1'b1;
            j_vec = '0;
            k_vec = count;
          end else begin
            j_vec = up_tgl;
            k_vec = up_tgl;
          end
        end
      end
      default: begin
        j_vec = '0;
        k_vec = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      resume_q <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      target_q <= target_d;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clock (clock),
      .reset (reset),
      .j     (j_vec[gi]),
      .k     (k_vec[gi]),
      .q     (count[gi])
    );
  end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Scoreboard bench for jk_counter_ctrl (WIDTH=4, MODULUS=10); down-count vectors run with JK_CTRL_DOWN_EN.
module tb_jk_counter_ctrl;
  import jk_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic [3:0] j_vec;
  logic [3:0] k_vec;
  logic       tc;
  logic       busy;
`ifdef JK_CTRL_DOWN_EN
  logic       dir;
`endif

  jk_counter_ctrl_if #(.WIDTH(4)) cmd_if ();

  jk_counter_ctrl #(.WIDTH(4), .MODULUS(10)) dut (
    .clock (clk),
    .reset (reset),
`ifdef JK_CTRL_DOWN_EN
    .dir   (dir),
`endif
    .cmd   (cmd_if),
    .count (count),
    .j_vec (j_vec),
    .k_vec (k_vec),
    .tc    (tc),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cnt;
    logic       tc;
    logic       rdy;
    logic       busy;
    logic       jk_chk;
    logic [3:0] j;
    logic [3:0] k;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected entry per observed cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("count", 16'(count), 16'(mon_e.cnt));
      check("tc", 16'(tc), 16'(mon_e.tc));
      check("cmd_ready", 16'(cmd_if.cmd_ready), 16'(mon_e.rdy));
      check("busy", 16'(busy), 16'(mon_e.busy));
      if (mon_e.jk_chk) begin
        check("j_vec", 16'(j_vec), 16'(mon_e.j));
        check("k_vec", 16'(k_vec), 16'(mon_e.k));
      end
    end
  end

  task automatic push_step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [3:0] c, input logic t, input logic r, input logic b);
    exp_t e;
    e.cnt = c; e.tc = t; e.rdy = r; e.busy = b;
    e.jk_chk = 1'b0; e.j = 4'd0; e.k = 4'd0;
    push_step(e);
  endtask

  task automatic cycjk(input logic [3:0] c, input logic t, input logic r, input logic b,
                       input logic [3:0] j, input logic [3:0] k);
    exp_t e;
    e.cnt = c; e.tc = t; e.rdy = r; e.busy = b;
    e.jk_chk = 1'b1; e.j = j; e.k = k;
    push_step(e);
  endtask

  task automatic issue(input op_e op, input logic [3:0] data);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    $display("cmd %s data=%0d t=%0t", op.name(), data, $time);
  endtask

  task automatic drop();
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_STOP;
    cmd_if.cmd_data  = 4'd0;
`ifdef JK_CTRL_DOWN_EN
    dir = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    cycjk(4'd0, 0, 0, 0, 4'd0, 4'd0);            // reset held: ready low
    reset = 1'b0;
    cycjk(4'd0, 0, 1, 0, 4'd0, 4'd0);

    // RUN from 0: 0..9,0 with tc only at 9
    issue(OP_RUN, 4'd0);
    cycjk(4'd0, 0, 1, 0, 4'd0, 4'd0);
    drop();
    for (int i = 0; i <= 10; i++) cyc(4'(i % 10), (i == 9), 1, 1);
    cyc(4'd1, 0, 1, 1);
    cyc(4'd2, 0, 1, 1);

    // STOP accepted in the count==3 cycle: holds at 4
    issue(OP_STOP, 4'd0);
    cyc(4'd3, 0, 1, 1);
    drop();
    for (int i = 0; i < 5; i++) cycjk(4'd4, 0, 1, 0, 4'd0, 4'd0);

    issue(OP_RUN, 4'd0);
    cycjk(4'd4, 0, 1, 0, 4'd0, 4'd0);
    drop();
    cyc(4'd4, 0, 1, 1);
    cyc(4'd5, 0, 1, 1);

    // LOAD 3 while running: APPLY, then resume from 3
    issue(OP_LOAD, 4'd3);
    cyc(4'd6, 0, 1, 1);
    drop();
    cycjk(4'd7, 0, 0, 1, 4'b0011, 4'b1100);
    cyc(4'd3, 0, 1, 1);
    cyc(4'd4, 0, 1, 1);
    cyc(4'd5, 0, 1, 1);

    issue(OP_STOP, 4'd0);
    cyc(4'd6, 0, 1, 1);
    drop();
    cycjk(4'd7, 0, 1, 0, 4'd0, 4'd0);

    // LOAD 13 saturates to 9; tc stays low outside RUN
    issue(OP_LOAD, 4'd13);
    cycjk(4'd7, 0, 1, 0, 4'd0, 4'd0);
    drop();
    cycjk(4'd7, 0, 0, 1, 4'b1001, 4'b0110);
    cycjk(4'd9, 0, 1, 0, 4'd0, 4'd0);

    // LOAD 7 from IDLE then hold
    issue(OP_LOAD, 4'd7);
    cyc(4'd9, 0, 1, 0);
    drop();
    cycjk(4'd9, 0, 0, 1, 4'b0111, 4'b1000);
    cycjk(4'd7, 0, 1, 0, 4'd0, 4'd0);
    cycjk(4'd7, 0, 1, 0, 4'd0, 4'd0);

    // CLEAR ignores data
    issue(OP_CLEAR, 4'd5);
    cyc(4'd7, 0, 1, 0);
    drop();
    cycjk(4'd7, 0, 0, 1, 4'b0000, 4'b1111);
    cycjk(4'd0, 0, 1, 0, 4'd0, 4'd0);

    // LOAD exactly MODULUS saturates; RUN from 9 wraps
    issue(OP_LOAD, 4'd10);
    cyc(4'd0, 0, 1, 0);
    drop();
    cycjk(4'd0, 0, 0, 1, 4'b1001, 4'b0110);
    cyc(4'd9, 0, 1, 0);
    issue(OP_RUN, 4'd0);
    cyc(4'd9, 0, 1, 0);
    drop();
    cycjk(4'd9, 1, 1, 1, 4'b0000, 4'b1001);
    cyc(4'd0, 0, 1, 1);
    cyc(4'd1, 0, 1, 1);

    // Reset during APPLY discards the load
    issue(OP_LOAD, 4'd5);
    cyc(4'd2, 0, 1, 1);
    drop();
    reset = 1'b1;
    cyc(4'd3, 0, 0, 1);
    reset = 1'b0;
    cycjk(4'd0, 0, 1, 0, 4'd0, 4'd0);
    cycjk(4'd0, 0, 1, 0, 4'd0, 4'd0);

`ifdef JK_CTRL_DOWN_EN
    // Down-count from 1: 1,0,9,8 with tc at 0
    issue(OP_LOAD, 4'd1);
    cyc(4'd0, 0, 1, 0);
    drop();
    cyc(4'd0, 0, 0, 1);
    cyc(4'd1, 0, 1, 0);
    dir = 1'b1;
    issue(OP_RUN, 4'd0);
    cyc(4'd1, 0, 1, 0);
    drop();
    cyc(4'd1, 0, 1, 1);
    cycjk(4'd0, 1, 1, 1, 4'b1001, 4'b0000);
    cyc(4'd9, 0, 1, 1);
    cyc(4'd8, 0, 1, 1);
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_counter_ctrl.md
# jk_counter_ctrl

Sequencer for a bank of JK flip-flop cells configured as a programmable modulo-N synchronous counter. It accepts commands over a valid/ready handshake: clear, load, run, stop. It computes each cell's J/K inputs every cycle and flags the terminal count. It is the control layer above the JK cell and the standard way the design builds counters from JK storage.

## Interface
- WIDTH, 4, number of JK cells / counter bits (1..16)
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2^WIDTH
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command this cycle
- cmd_op  in  2  00 STOP, 01 CLEAR, 10 LOAD, 11 RUN
- cmd_data  in  WIDTH  load value, used only with LOAD
- dir  in  1  0 up, 1 down; present only with JK_CTRL_DOWN_EN
- count  out  WIDTH  Q outputs of the cell bank
- j_vec, k_vec  out  WIDTH each  J/K drive currently applied to the cells
- tc  out  1  terminal count: the wrap happens on the next edge
- busy  out  1  high in RUN and APPLY

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, count 0, j_vec/k_vec 0, tc 0, busy 0, cmd_ready 0 while reset is high.
- Handshake: a command is accepted on an edge with cmd_valid && cmd_ready. cmd_valid and its fields must be held until they are accepted.
- States: IDLE, RUN, APPLY. A 1-bit resume flag records whether APPLY returns to RUN or IDLE.
- IDLE:
  - cmd_ready=1; j_vec=k_vec=0, so the cells hold.
  - RUN goes to RUN. STOP is accepted with no effect.
  - CLEAR or LOAD goes to APPLY with resume=0.
- RUN:
  - cmd_ready=1; count advances every cycle.
  - STOP goes to IDLE. CLEAR or LOAD goes to APPLY with resume=1. RUN is accepted with no effect.
- APPLY (exactly 1 cycle):
  - cmd_ready=0. The target value is latched at acceptance.
  - For each bit: j=target[i], k=~target[i]. This forces count=target at the end of APPLY.
  - Next state is RUN if resume=1, else IDLE.
- Load clamp: a LOAD value >= MODULUS is saturated to MODULUS-1. CLEAR uses target=0.
- Up-count J/K in RUN:
  - Normal: bit i toggles (j=k=1) iff all lower bits of count are 1.
  - At count==MODULUS-1: j=0 and k=count[i], so the next value is 0.
- Down-count (macro only):
  - Normal: bit i toggles iff all lower bits are 0.
  - At count==0: j=~count[i] and k=0 on bits where (MODULUS-1) has a 1, and j=0 and k=count[i] elsewhere, so the next value is MODULUS-1.
- tc is combinational: (state==RUN) && count==MODULUS-1 when up, or count==0 when down.
- dir may change at any time and takes effect on the next RUN cycle.

## Timing
- Accept edge E0 for LOAD/CLEAR: APPLY during the cycle after E0. The new count is visible after edge E1 (1-cycle latency). cmd_ready returns high after E1.
- Accept edge E0 for RUN: the first increment lands on E1.
- Accept edge E0 for STOP: no change on E1; the count holds from E1 onward.
- A tc-high cycle always precedes the wrap edge. tc is high for exactly one cycle per wrap.
- Reset asserted during APPLY or RUN: reset wins on that edge. The pending load is discarded.
- MODULUS==2^WIDTH: the wrap equals natural binary overflow; the same rules apply.

## Configuration
- JK_CTRL_DOWN_EN defined: the dir port exists and down-count/underflow-wrap logic is built.
- JK_CTRL_DOWN_EN undefined: the dir port is absent, the block is up-count only, and tc compares only against MODULUS-1.

## Structure
- Shared package jk_ctrl_pkg holds:
  - the cmd_op encodings (OP_STOP, OP_CLEAR, OP_LOAD, OP_RUN);
  - the state encodings (ST_IDLE, ST_RUN, ST_APPLY).
- Sub-module jk_cell: one JK flip-flop with synchronous active-high reset to 0, ports clock, reset, j, k, q.
  - Instantiate WIDTH copies via generate.
  - count is the concatenation of the q outputs.
  - The controller never writes count directly; every change goes through J/K.

## Test plan
- Reset, then RUN with WIDTH=4, MODULUS=10, up: count goes 0,1,…,9,0. tc is high only in the count==9 cycle.
- LOAD 7 from IDLE: cmd_ready is 0 for one cycle, count=7 one cycle after acceptance, then it holds at 7.
- LOAD 13 with MODULUS=10: count saturates to 9.
- LOAD 3 while RUN at count 5: after APPLY count=3, then 4,5,… (counting resumes automatically).
- STOP at count 4, wait 5 cycles, then RUN: count holds at 4, then 5; j_vec/k_vec are 0 while idle.
- JK_CTRL_DOWN_EN with dir=1 from count 1: count goes 1,0,9,8. tc is high in the count==0 cycle. Reset asserted in the APPLY cycle gives count=0 and state IDLE.
